// File: rtl/jtcps_dtack_multi.sv
// jtcps_dtack_multi: multi-channel 68000 DTACKn generator with per-channel waits, ok handshake and timeout.
// Define JTCPS_DTACK_RECOVER_EN to add the wait-debt recovery counter and the debt_cnt port.
module jtcps_dtack_multi #(
  parameter int CH  = 4,
  parameter int WW  = 2,
  parameter int TOW = 8,
  parameter int RCW = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cen,
  input  logic                  cenb,
  input  logic                  ASn,
  input  logic [CH-1:0]         bus_cs,
  input  logic [CH-1:0]         bus_ok,
  input  logic [CH*WW-1:0]      ch_wait,
  input  logic                  one_wait,
  input  logic                  err_clr,
  output logic                  DTACKn,
  output logic                  busy,
  output logic                  tout_err,
  output logic [$clog2(CH)-1:0] tout_ch
`ifdef JTCPS_DTACK_RECOVER_EN
  ,
  output logic [RCW-1:0]        debt_cnt
`endif
);

  localparam int SW = $clog2(CH);
  localparam int CW = WW + 1;
  localparam logic [TOW-1:0] TLAST = {{(TOW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, FIXED, OKWAIT, ACK} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic            r_hit;
  logic [CW-1:0]   r_wcnt;
  logic [TOW-1:0]  r_tcnt;
  logic            r_first;
  logic            r_ok_s;
  logic            r_dtack_n;
  logic            r_busy;
  logic            r_tout_err;
  logic [SW-1:0]   r_tout_ch;
  logic            r_armed;

  logic [SW-1:0]   w_sel;
  logic            w_hit;
  logic [CW-1:0]   w_wait;
  logic [CW-1:0]   w_wcnt;
  logic [CW-1:0]   w_wcnt_eff;
  logic            w_start;

  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (bus_cs[i]) begin
        w_sel = SW'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign w_wait  = w_hit ? {1'b0, ch_wait[w_sel*WW +: WW]} : '0;
  assign w_wcnt  = w_wait + {{WW{1'b0}}, one_wait};
  // r_armed demands a fresh ASn fall, so a reset mid-access cannot restart the old cycle
  assign w_start = cen && (r_state == IDLE) && !ASn && r_armed;

`ifdef JTCPS_DTACK_RECOVER_EN
  localparam int XW = (RCW > CW) ? RCW : CW;

  logic [RCW-1:0] r_debt;
  logic [RCW-1:0] w_debt_nxt;
  logic [XW-1:0]  w_debt_x;
  logic [XW-1:0]  w_wcnt_x;

  always_comb begin
    w_debt_x = XW'(r_debt);
    w_wcnt_x = XW'(w_wcnt);
    if (w_debt_x >= w_wcnt_x) begin
      w_wcnt_eff = '0;
      w_debt_nxt = RCW'(w_debt_x - w_wcnt_x);
    end else begin
      w_wcnt_eff = CW'(w_wcnt_x - w_debt_x);
      w_debt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_debt <= '0;
    end else if (cen) begin
      if (w_start)
        r_debt <= w_debt_nxt;
      else if (r_state == OKWAIT && !r_first && r_debt != '1)
        r_debt <= r_debt + RCW'(1);
    end
  end

  assign debt_cnt = r_debt;
`else
  assign w_wcnt_eff = w_wcnt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_ok_s <= 1'b0;
    else if (cenb)
      r_ok_s <= bus_ok[r_sel];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_hit      <= 1'b0;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_first    <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_busy     <= 1'b0;
      r_tout_err <= 1'b0;
      r_tout_ch  <= '0;
      r_armed    <= 1'b0;
    end else begin
      if (ASn) r_armed <= 1'b1;
      if (err_clr) r_tout_err <= 1'b0;
      if (cen) begin
        case (r_state)
          IDLE: begin
            if (!ASn && r_armed) begin
              r_armed <= 1'b0;
              r_sel   <= w_sel;
              r_hit   <= w_hit;
              r_wcnt  <= w_wcnt_eff;
              r_tcnt  <= '0;
              r_first <= 1'b1;
              if (w_wcnt_eff != '0) begin
                r_state <= FIXED;
                r_busy  <= 1'b1;
              end else if (w_hit) begin
                r_state <= OKWAIT;
                r_busy  <= 1'b1;
              end else begin
                r_state   <= ACK;
                r_dtack_n <= 1'b0;
              end
            end
          end
          FIXED: begin
            if (ASn) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_wcnt == '0) begin
              if (r_hit) begin
                r_state <= OKWAIT;
                r_tcnt  <= '0;
                r_first <= 1'b1;
              end else begin
                r_state   <= ACK;
                r_busy    <= 1'b0;
                r_dtack_n <= 1'b0;
              end
            end else begin
              r_wcnt <= r_wcnt - CW'(1);
            end
          end
          OKWAIT: begin
            r_first <= 1'b0;
            r_tcnt  <= r_tcnt + TOW'(1);
            if (ASn) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_ok_s && !r_first) begin
              r_state   <= ACK;
              r_busy    <= 1'b0;
              r_dtack_n <= 1'b0;
            end else if (r_tcnt == TLAST) begin
              // a timeout set overrides a coincident err_clr
              r_state    <= ACK;
              r_busy     <= 1'b0;
              r_dtack_n  <= 1'b0;
              r_tout_err <= 1'b1;
              r_tout_ch  <= r_sel;
            end
          end
          ACK: begin
            if (ASn) begin
              r_state   <= IDLE;
              r_dtack_n <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign DTACKn   = r_dtack_n | ASn;
  assign busy     = r_busy;
  assign tout_err = r_tout_err;
  assign tout_ch  = r_tout_ch;

endmodule

// File: tb/tb_jtcps_dtack_multi.sv
// Bench for jtcps_dtack_multi: vector table plus hand sequences for timeout, abort, reset and recovery.
// Expected acknowledge latencies are counted in cen cycles, cen 0 being the first cen with ASn low.
module tb_jtcps_dtack_multi;

  logic       clk, rstn, cen, cenb, ASn, one_wait, err_clr;
  logic [3:0] bus_cs, bus_ok;
  logic [7:0] ch_wait;
  logic       DTACKn, busy, tout_err;
  logic [1:0] tout_ch;
`ifdef JTCPS_DTACK_RECOVER_EN
  logic [3:0] debt_cnt;
`endif

  jtcps_dtack_multi #(.CH(4), .WW(2), .TOW(4), .RCW(4)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .cenb(cenb), .ASn(ASn),
    .bus_cs(bus_cs), .bus_ok(bus_ok), .ch_wait(ch_wait),
    .one_wait(one_wait), .err_clr(err_clr),
    .DTACKn(DTACKn), .busy(busy), .tout_err(tout_err), .tout_ch(tout_ch)
`ifdef JTCPS_DTACK_RECOVER_EN
    , .debt_cnt(debt_cnt)
`endif
  );

  typedef struct {
    logic [3:0] cs;
    logic [7:0] cw;
    logic       ow;
    int         ok_at;
    logic [3:0] okm;
    logic [3:0] noise;
    int         lat;
    logic       busy0;
    logic       tout;
    logic [1:0] tch;
  } vec_t;

  typedef struct {
    int         lat;
    logic       tout;
    logic [1:0] tch;
  } exp_t;

  vec_t tv[10];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ph = 3;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen = 0;
    cenb = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      cen = (ph == 0);
      cenb = (ph == 2);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic next_cen();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (cen !== 1'b1 && n < 8);
    #1;
  endtask

  task automatic do_access(input logic [3:0] cs, input logic [7:0] cw, input logic ow,
                           input int ok_at, input logic [3:0] okm, input logic [3:0] noise,
                           input int clr_at, output int lat, output logic busy0, output logic mid);
    logic tog = 1'b0;
    bus_cs = cs;
    ch_wait = cw;
    one_wait = ow;
    bus_ok = (ok_at < 0) ? okm : 4'b0;
    lat = -1;
    busy0 = 1'bx;
    mid = 1'bx;
    next_cen();
    ASn = 0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      next_cen();
      if (k == clr_at + 1) err_clr = 0;
      if (k == 0) busy0 = busy;
      if (DTACKn === 1'b0) begin
        lat = k;
      end else begin
        tog = ~tog;
        bus_ok = (((ok_at < 0) || (k >= ok_at)) ? okm : 4'b0) | (noise & {4{tog}});
      end
      if (k == clr_at) begin
        err_clr = 1;
        @(posedge clk);
        #1;
        mid = tout_err;
      end
    end
  endtask

  task automatic release_bus();
    chk("busy_after_ack", 32'(busy), 32'd0);
    ASn = 1;
    #1;
    chk("dtack_release", 32'(DTACKn), 32'd1);
    next_cen();
    next_cen();
    bus_ok = 4'b0;
  endtask

  task automatic clear_err();
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    chk("err_cleared", 32'(tout_err), 32'd0);
  endtask

  initial begin
    int   lat_got;
    int   lows;
    logic b0, mid;
    exp_t e;

    tv[0] = '{4'b0010, 8'b00_00_10_00, 1'b0,  5, 4'b0010, 4'b0000,  6, 1'b1, 1'b0, 2'd0};
    tv[1] = '{4'b0000, 8'b00_00_00_00, 1'b1, 99, 4'b0000, 4'b0101,  2, 1'b1, 1'b0, 2'd0};
    tv[2] = '{4'b1010, 8'b00_00_10_00, 1'b0,  5, 4'b0010, 4'b1001,  6, 1'b1, 1'b0, 2'd0};
    tv[3] = '{4'b0001, 8'b00_00_00_00, 1'b0, -1, 4'b0001, 4'b0000,  2, 1'b1, 1'b0, 2'd0};
    tv[4] = '{4'b0100, 8'b00_11_00_00, 1'b1, -1, 4'b0100, 4'b0000,  7, 1'b1, 1'b0, 2'd0};
    tv[5] = '{4'b1000, 8'b11_00_00_00, 1'b0,  9, 4'b1000, 4'b0000, 10, 1'b1, 1'b0, 2'd0};
    tv[6] = '{4'b0000, 8'b11_11_11_11, 1'b0, 99, 4'b0000, 4'b0000,  0, 1'b0, 1'b0, 2'd0};
    tv[7] = '{4'b0010, 8'b00_00_11_00, 1'b1,  8, 4'b0010, 4'b0000,  9, 1'b1, 1'b0, 2'd0};
    tv[8] = '{4'b0100, 8'b00_00_00_00, 1'b0, 99, 4'b0100, 4'b0000, 15, 1'b1, 1'b1, 2'd2};
    tv[9] = '{4'b1000, 8'b00_11_11_11, 1'b0, 99, 4'b1000, 4'b0111, 15, 1'b1, 1'b1, 2'd3};

    rstn = 0;
    ASn = 1;
    bus_cs = 0;
    bus_ok = 0;
    ch_wait = 0;
    one_wait = 0;
    err_clr = 0;
    #1;
    chk("rst_dtack", 32'(DTACKn), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tout_err", 32'(tout_err), 32'd0);
    chk("rst_tout_ch", 32'(tout_ch), 32'd0);
    #22;
    rstn = 1;
    next_cen();

    for (int i = 0; i < 10; i++) begin
      sb.push_back('{tv[i].lat, tv[i].tout, tv[i].tch});
      do_access(tv[i].cs, tv[i].cw, tv[i].ow, tv[i].ok_at, tv[i].okm, tv[i].noise, -10,
                lat_got, b0, mid);
      e = sb.pop_front();
      chk($sformatf("vec%0d_latency", i), lat_got, e.lat);
      chk($sformatf("vec%0d_busy_start", i), 32'(b0), 32'(tv[i].busy0));
      chk($sformatf("vec%0d_tout_err", i), 32'(tout_err), 32'(e.tout));
      if (e.tout) chk($sformatf("vec%0d_tout_ch", i), 32'(tout_ch), 32'(e.tch));
      release_bus();
      clear_err();
    end

    // first timeout on channel 2, then a second one with err_clr held across its cen
    sb.push_back('{15, 1'b1, 2'd2});
    do_access(4'b0100, 8'h00, 1'b0, 99, 4'b0100, 4'b0000, -10, lat_got, b0, mid);
    e = sb.pop_front();
    chk("to1_latency", lat_got, e.lat);
    chk("to1_tout_err", 32'(tout_err), 32'(e.tout));
    chk("to1_tout_ch", 32'(tout_ch), 32'(e.tch));
    release_bus();
    sb.push_back('{15, 1'b1, 2'd2});
    do_access(4'b0100, 8'h00, 1'b0, 99, 4'b0100, 4'b0000, 14, lat_got, b0, mid);
    e = sb.pop_front();
    chk("to2_latency", lat_got, e.lat);
    chk("to2_clear_before_set", 32'(mid), 32'd0);
    chk("to2_set_wins", 32'(tout_err), 32'(e.tout));
    release_bus();
    clear_err();

    // early ASn rise during FIXED aborts without error
    bus_cs = 4'b0010;
    ch_wait = 8'b00_00_10_00;
    one_wait = 0;
    bus_ok = 0;
    next_cen();
    ASn = 0;
    next_cen();
    chk("abort_busy_start", 32'(busy), 32'd1);
    next_cen();
    ASn = 1;
    next_cen();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dtack", 32'(DTACKn), 32'd1);
    chk("abort_tout_err", 32'(tout_err), 32'd0);
    sb.push_back('{0, 1'b0, 2'd0});
    do_access(4'b0000, 8'h00, 1'b0, 99, 4'b0000, 4'b0000, -10, lat_got, b0, mid);
    e = sb.pop_front();
    chk("after_abort_latency", lat_got, e.lat);
    release_bus();

    // reset while waiting for ok with ASn held low
    bus_cs = 4'b0100;
    ch_wait = 8'h00;
    bus_ok = 0;
    next_cen();
    ASn = 0;
    repeat (4) next_cen();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    bus_cs = 4'b0000;
    rstn = 0;
    #1;
    chk("midrst_dtack", 32'(DTACKn), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      next_cen();
      if (DTACKn !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("postrst_no_restart", lows, 0);
    ASn = 1;
    next_cen();
    sb.push_back('{0, 1'b0, 2'd0});
    do_access(4'b0000, 8'h00, 1'b0, 99, 4'b0000, 4'b0000, -10, lat_got, b0, mid);
    e = sb.pop_front();
    chk("postrst_fresh_latency", lat_got, e.lat);
    release_bus();

`ifdef JTCPS_DTACK_RECOVER_EN
    // ok seen on cen 4 -> cens 2,3,4 count as debt
    sb.push_back('{4, 1'b0, 2'd0});
    do_access(4'b0001, 8'h00, 1'b0, 3, 4'b0001, 4'b0000, -10, lat_got, b0, mid);
    e = sb.pop_front();
    chk("rec_latency_a", lat_got, e.lat);
    chk("rec_debt3", 32'(debt_cnt), 32'd3);
    release_bus();
    bus_cs = 4'b0010;
    ch_wait = 8'b00_00_10_00;
    one_wait = 0;
    bus_ok = 4'b0010;
    next_cen();
    ASn = 0;
    next_cen();
    chk("rec_debt1", 32'(debt_cnt), 32'd1);
    chk("rec_busy", 32'(busy), 32'd1);
    next_cen();
    chk("rec_ignore_cen", 32'(DTACKn), 32'd1);
    next_cen();
    chk("rec_ack_no_fixed", 32'(DTACKn), 32'd0);
    release_bus();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/jtcps_dtack_multi.md
Name: jtcps_dtack_multi

Overview:
- Parametrised 68000 DTACKn generator for CPS-family main CPU buses; successor to the fixed single-path DTACK logic used with the CPS2 main CPU.
- Supports CH chip-select channels, each with:
  - its own programmable fixed wait count;
  - its own ready (ok) handshake.
- Adds a per-access timeout with error capture, so a stalled SDRAM/QSound path can no longer hang the CPU.
- Sits between the main-CPU address decoder and fx68k; paced by the CPU phi1/phi2 clock enables.

Parameters:
- CH, 4: number of chip-select channels.
- WW, 2: width of each channel's fixed wait field, in cen cycles.
- TOW, 8: timeout counter width. An ok wait is aborted after 2**TOW-1 cen cycles.
- RCW, 4: width of the recovery debt counter. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- cen  in  1  CPU phi1 enable.
- cenb  in  1  CPU phi2 enable.
- ASn  in  1  68000 address strobe.
- bus_cs  in  CH  registered chip selects; bit 0 has highest priority.
- bus_ok  in  CH  per-channel data-ready.
- ch_wait  in  CH*WW  fixed wait per channel; channel i uses bits [i*WW +: WW]. Static config.
- one_wait  in  1  adds one extra wait to the current access.
- err_clr  in  1  clears timeout error state.
- DTACKn  out  1  to CPU.
- busy  out  1  high while an access is open and not yet acknowledged.
- tout_err  out  1  sticky timeout flag.
- tout_ch  out  $clog2(CH)  index of the channel that timed out.

Behaviour:
- Reset (rstn low, asynchronous): DTACKn=1, busy=0, tout_err=0, tout_ch=0, state=IDLE, all counters 0. Reset mid-access leaves the FSM in IDLE and DTACKn high, whatever ASn does.
- All state changes happen on clk edges with cen=1, except the ASn release path below. cenb is used only to sample bus_ok.
- FSM states: IDLE, FIXED, OKWAIT, ACK.
- IDLE:
  - Condition: on cen with ASn=0.
  - Latch sel = lowest-index set bit of bus_cs.
  - Load wcnt = ch_wait[sel] + one_wait. Width is WW+1, no overflow.
  - If bus_cs==0: sel=none and wcnt=one_wait.
  - Go to FIXED if wcnt>0. Otherwise go to OKWAIT when a channel is selected, or to ACK when none is.
  - busy=1 from this cycle.
- FIXED:
  - Decrement wcnt each cen.
  - Leave when wcnt reaches 0: to OKWAIT if a channel is selected, else to ACK.
- OKWAIT:
  - ok_s is bus_ok[sel] registered on cenb.
  - ok_s is ignored on the first cen after entering OKWAIT, to reject stale ok from the previous access.
  - On a later cen with ok_s=1: go to ACK.
  - tcnt counts cen cycles in OKWAIT and is cleared on entry.
  - When tcnt reaches 2**TOW-1: go to ACK, set tout_err=1, latch tout_ch=sel.
- ACK:
  - DTACKn=0 (registered), busy=0.
  - Hold until ASn=1, then go to IDLE.
- ASn release: DTACKn = DTACKn_reg | ASn. DTACKn therefore goes high in the same clk cycle ASn rises, with no cen needed.
- Early ASn rise: if ASn rises in FIXED or OKWAIT (aborted access), go to IDLE on the next cen with no error.
- err_clr: clears tout_err on any clk. If it coincides with a new timeout, set wins.
- bus_cs is sampled only in IDLE; later changes within the access are ignored.

Optional Feature:
- Macro: JTCPS_DTACK_RECOVER_EN.
- Defined: an RCW-bit debt counter tracks cycles lost to slow memory.
  - +1 per cen spent in OKWAIT after the ignore cycle; saturates at 2**RCW-1.
  - In IDLE, when wcnt>0 and debt>=wcnt: skip FIXED entirely and subtract wcnt from debt.
  - When 0<debt<wcnt: load wcnt-debt and clear debt.
  - Debt clears on reset only. Output debt_cnt [RCW-1:0] is added.
- Undefined: no debt logic and no debt_cnt port; fixed waits are always honoured.

Test Plan:
- ch_wait=8'b00_00_10_00, bus_cs=4'b0010, bus_ok[1] high 5 cen after ASn fall, one_wait=0 -> DTACKn low on cen 6 after ASn fall; DTACKn high in the clk cycle ASn rises.
- bus_cs=0, one_wait=1, ASn falls -> DTACKn low exactly 2 cen later; busy high for those cycles only.
- bus_cs=4'b1010 (two bits set) -> channel 1 selected; bus_ok[3] toggling has no effect; ack follows bus_ok[1].
- TOW=4, bus_cs=4'b0100, bus_ok held 0 -> DTACKn low after wait + 15 cen, tout_err=1, tout_ch=2. Then err_clr pulsed coincident with a second timeout -> tout_err stays 1.
- bus_ok[0] left high from the previous access, new access on channel 0 with ok already high -> ack not given on the first OKWAIT cen; given on the second.
- rstn pulsed low while in OKWAIT with ASn low -> DTACKn=1 immediately and stays high until a fresh ASn fall. With JTCPS_DTACK_RECOVER_EN: debt=3, ch_wait=2 -> zero fixed waits and debt_cnt=1.
